// File: rtl/muldiv_sequencer_pkg.sv
// +----------------------------------------------------------------------+
// | muldiv_sequencer_pkg : shared types and constants for the MULTU/DIVU |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package muldiv_sequencer_pkg;

  localparam int WIDTH_DEFAULT = 32;
  localparam int CNT_W_DEFAULT = $clog2(WIDTH_DEFAULT) + 1;

  localparam logic OP_MULTU = 1'b0;
  localparam logic OP_DIVU  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_step.sv
// +----------------------------------------------------------------------+
// | muldiv_step : one combinational shift-add / restoring-divide step    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module muldiv_step
  import muldiv_sequencer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             op,
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] nxt_hi,
  output logic [WIDTH-1:0] nxt_lo
);

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] diff;
  logic             rem_ge;

  always_comb begin
    mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, b} : '0);
    rem_sh  = {acc_hi, acc_lo[WIDTH-1]};
    rem_ge  = (rem_sh >= {1'b0, b});
    // When rem_sh >= b the true difference is below 2^WIDTH, so a WIDTH-bit subtract is exact.
    diff    = rem_sh[WIDTH-1:0] - b;

    if (op == OP_MULTU) begin
      nxt_hi = mul_sum[WIDTH:1];
      nxt_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end else if (rem_ge) begin
      nxt_hi = diff;
      nxt_lo = {acc_lo[WIDTH-2:0], 1'b1};
    end else begin
      nxt_hi = rem_sh[WIDTH-1:0];
      nxt_lo = {acc_lo[WIDTH-2:0], 1'b0};
    end
  end

endmodule

`default_nettype wire

// File: rtl/muldiv_sequencer.sv
// +----------------------------------------------------------------------+
// | muldiv_sequencer : multi-cycle MULTU/DIVU sequencer owning HI/LO     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int                CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(WIDTH - 1);

  state_t           state_q,  state_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic             op_q,     op_d;
  logic [WIDTH-1:0] b_q,      b_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] hi_q,     hi_d;
  logic [WIDTH-1:0] lo_q,     lo_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;

  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;

  muldiv_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .op     (op_q),
    .acc_hi (acc_hi_q),
    .acc_lo (acc_lo_q),
    .b      (b_q),
    .nxt_hi (step_hi),
    .nxt_lo (step_lo)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    b_d      = b_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          // Multiply keeps the multiplier in the low half; divide keeps the dividend there.
          op_d     = op;
          b_d      = (op == OP_MULTU) ? srca : srcb;
          acc_hi_d = '0;
          acc_lo_d = (op == OP_MULTU) ? srcb : srca;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = ST_RUN;
        end else begin
          if (wr_hi) hi_d = wdata;
          if (wr_lo) lo_d = wdata;
        end
      end
      ST_RUN: begin
        acc_hi_d = step_hi;
        acc_lo_d = step_lo;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          hi_d    = step_hi;
          lo_d    = step_lo;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= OP_MULTU;
      b_q      <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      b_q      <= b_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

`default_nettype wire
